// File: rtl/time_keeper_if.sv
// Bundle between the time keeper and its setup/display peer.
// The master drives load requests and mode; the slave (time keeper) returns time and pulses.
interface time_keeper_if;
  logic [23:0] setup_data;
  logic        setup_imp;
  logic [1:0]  rezhim;
  logic [23:0] data_ch;
  logic        sec_tick;
  logic        day_wrap;
  logic        loaded;

  modport master (
    output setup_data,
    output setup_imp,
    output rezhim,
    input  data_ch,
    input  sec_tick,
    input  day_wrap,
    input  loaded
  );

  modport slave (
    input  setup_data,
    input  setup_imp,
    input  rezhim,
    output data_ch,
    output sec_tick,
    output day_wrap,
    output loaded
  );
endinterface

// File: rtl/time_keeper.sv
// Free-running hh:mm:ss clock with a prescaled seconds tick and an edge-triggered time load.
// All outputs come straight from registers; a load on the same edge as a tick wins.
module time_keeper #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic          clock,
  input  logic          reset,
  time_keeper_if.slave  tk
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam int NUM_FIELDS = 3;

  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic               imp_d_reg, imp_d_next;
  logic [23:0]        time_reg, time_next;
  logic               sec_tick_reg, sec_tick_next;
  logic               day_wrap_reg, day_wrap_next;
  logic               loaded_reg, loaded_next;

  logic               load_ev;
  logic               sec_ev;
  logic [23:0]        load_value;
  logic [23:0]        inc_value;
  logic [NUM_FIELDS-1:0] at_max;
  logic [NUM_FIELDS-1:0] inc_en;
  logic               day_carry;

  assign load_ev = tk.setup_imp & ~imp_d_reg;
  assign sec_ev  = (presc_reg == PRESC_MAX);

  // Field 0 = seconds, 1 = minutes, 2 = hours; a field steps only when all lower fields wrap.
  assign inc_en    = {at_max[1] & at_max[0], at_max[0], 1'b1};
  assign day_carry = &at_max;

  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      localparam logic [7:0] FIELD_MAX = (gi == 2) ? 8'd23 : 8'd59;

      logic [7:0] cur_field;
      logic [7:0] set_field;

      assign cur_field  = time_reg[gi*8 +: 8];
      assign set_field  = tk.setup_data[gi*8 +: 8];
      assign at_max[gi] = (cur_field == FIELD_MAX);

      // Out-of-range requests clear only the offending field.
      assign load_value[gi*8 +: 8] = (set_field > FIELD_MAX) ? 8'd0 : set_field;

      always_comb begin
        inc_value[gi*8 +: 8] = cur_field;
        if (inc_en[gi]) begin
          inc_value[gi*8 +: 8] = at_max[gi] ? 8'd0 : (cur_field + 8'd1);
        end
      end
    end
  endgenerate

  always_comb begin
    presc_next    = presc_reg;
    imp_d_next    = tk.setup_imp;
    time_next     = time_reg;
    sec_tick_next = 1'b0;
    day_wrap_next = 1'b0;
    loaded_next   = 1'b0;

    if (load_ev) begin
      // The pending increment is discarded and the new second starts from a fresh phase.
      time_next   = load_value;
      presc_next  = '0;
      loaded_next = 1'b1;
    end else if (sec_ev) begin
      time_next     = inc_value;
      presc_next    = '0;
      sec_tick_next = (tk.rezhim != 2'd3);
      day_wrap_next = day_carry;
    end else begin
      presc_next = presc_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_reg    <= '0;
      imp_d_reg    <= 1'b0;
      time_reg     <= '0;
      sec_tick_reg <= 1'b0;
      day_wrap_reg <= 1'b0;
      loaded_reg   <= 1'b0;
    end else begin
      presc_reg    <= presc_next;
      imp_d_reg    <= imp_d_next;
      time_reg     <= time_next;
      sec_tick_reg <= sec_tick_next;
      day_wrap_reg <= day_wrap_next;
      loaded_reg   <= loaded_next;
    end
  end

  assign tk.data_ch  = time_reg;
  assign tk.sec_tick = sec_tick_reg;
  assign tk.day_wrap = day_wrap_reg;
  assign tk.loaded   = loaded_reg;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_HZ=4: reset, day wrap, range-checked load,
// load/tick collision, held load request, setup-mode masking and asynchronous reset.
module tb_time_keeper;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  time_keeper_if tk_if();

  time_keeper #(.CLK_HZ(4)) dut (
    .clock (clock),
    .reset (reset),
    .tk    (tk_if)
  );

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [23:0] exp_data;
    logic        exp_tick;
    tk_if.setup_data = 24'h0;
    tk_if.setup_imp  = 1'b0;
    tk_if.rezhim     = 2'd0;
    reset = 1'b0;
    step();
    step();
    checks++;
    if (tk_if.data_ch !== 24'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected %h", tk_if.data_ch, 24'h0);
    end
    checks++;
    if ({tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected %b",
               {tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded}, 3'b000);
    end
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_data = (i >= 4) ? 24'h000001 : 24'h000000;
      exp_tick = (i == 4);
      checks++;
      if (tk_if.data_ch !== exp_data) begin
        failures++;
        $display("FAIL count_from_reset cyc%0d: got %h expected %h", i, tk_if.data_ch, exp_data);
      end
      checks++;
      if (tk_if.sec_tick !== exp_tick) begin
        failures++;
        $display("FAIL tick_from_reset cyc%0d: got %b expected %b", i, tk_if.sec_tick, exp_tick);
      end
    end
    $display("reset released, time after 5 cycles = %h", tk_if.data_ch);
  endtask

  task automatic test_day_wrap();
    logic [23:0] exp_data;
    tk_if.rezhim     = 2'd2;
    tk_if.setup_data = 24'h173B3A;
    tk_if.setup_imp  = 1'b1;
    step();
    checks++;
    if (tk_if.data_ch !== 24'h173B3A || tk_if.loaded !== 1'b1) begin
      failures++;
      $display("FAIL load_23_59_58: got data=%h loaded=%b expected data=%h loaded=1",
               tk_if.data_ch, tk_if.loaded, 24'h173B3A);
    end
    tk_if.setup_imp = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_data = (i < 4) ? 24'h173B3A : (i < 8) ? 24'h173B3B : 24'h000000;
      checks++;
      if (tk_if.data_ch !== exp_data) begin
        failures++;
        $display("FAIL wrap_data cyc%0d: got %h expected %h", i, tk_if.data_ch, exp_data);
      end
      checks++;
      if ({tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded} !== {(i == 4 || i == 8), (i == 8), 1'b0}) begin
        failures++;
        $display("FAIL wrap_pulses cyc%0d: got tick/wrap/load=%b expected %b", i,
                 {tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded},
                 {(i == 4 || i == 8), (i == 8), 1'b0});
      end
    end
    $display("load 173b3a, after 9 cycles time = %h", tk_if.data_ch);
  endtask

  task automatic test_range_check();
    tk_if.rezhim     = 2'd0;
    tk_if.setup_data = 24'h3C4018;
    tk_if.setup_imp  = 1'b1;
    step();
    checks++;
    if (tk_if.data_ch !== 24'h000018 || tk_if.loaded !== 1'b1) begin
      failures++;
      $display("FAIL range_load: got data=%h loaded=%b expected data=%h loaded=1",
               tk_if.data_ch, tk_if.loaded, 24'h000018);
    end
    tk_if.setup_imp = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (tk_if.data_ch !== ((i == 4) ? 24'h000019 : 24'h000018) || tk_if.sec_tick !== (i == 4)
          || tk_if.loaded !== 1'b0) begin
        failures++;
        $display("FAIL range_presc_restart cyc%0d: got data=%h tick=%b loaded=%b expected data=%h tick=%b loaded=0",
                 i, tk_if.data_ch, tk_if.sec_tick, tk_if.loaded,
                 (i == 4) ? 24'h000019 : 24'h000018, (i == 4));
      end
    end
    $display("load 3c4018, clamped and counted to %h", tk_if.data_ch);
  endtask

  task automatic test_load_vs_tick();
    // Prescaler was cleared on the last tick; three cycles bring it to its terminal count.
    for (int i = 1; i <= 3; i++) step();
    tk_if.setup_data = 24'h010203;
    tk_if.setup_imp  = 1'b1;
    step();
    checks++;
    if (tk_if.data_ch !== 24'h010203) begin
      failures++;
      $display("FAIL collide_data: got %h expected %h", tk_if.data_ch, 24'h010203);
    end
    checks++;
    if ({tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded} !== 3'b001) begin
      failures++;
      $display("FAIL collide_pulses: got tick/wrap/load=%b expected %b",
               {tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded}, 3'b001);
    end
    tk_if.setup_imp = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (tk_if.data_ch !== ((i == 4) ? 24'h010204 : 24'h010203) || tk_if.sec_tick !== (i == 4)) begin
        failures++;
        $display("FAIL collide_next_tick cyc%0d: got data=%h tick=%b expected data=%h tick=%b",
                 i, tk_if.data_ch, tk_if.sec_tick, (i == 4) ? 24'h010204 : 24'h010203, (i == 4));
      end
    end
    $display("load 010203 on tick edge, time now %h", tk_if.data_ch);
  endtask

  task automatic test_hold();
    logic [23:0] exp_data;
    tk_if.setup_data = 24'h020304;
    tk_if.setup_imp  = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 4)  tk_if.setup_data = 24'h050505;
      if (c == 11) tk_if.setup_imp  = 1'b0;
      step();
      exp_data = 24'h020304 + ((c >= 5) ? 24'd1 : 24'd0) + ((c >= 9) ? 24'd1 : 24'd0);
      checks++;
      if (tk_if.data_ch !== exp_data) begin
        failures++;
        $display("FAIL hold_data cyc%0d: got %h expected %h", c, tk_if.data_ch, exp_data);
      end
      checks++;
      if (tk_if.loaded !== (c == 1)) begin
        failures++;
        $display("FAIL hold_loaded cyc%0d: got %b expected %b", c, tk_if.loaded, (c == 1));
      end
    end
    $display("held load of 020304, time now %h", tk_if.data_ch);
  endtask

  task automatic test_mode3_reset();
    logic [23:0] exp_data;
    tk_if.rezhim = 2'd3;
    for (int j = 1; j <= 8; j++) begin
      step();
      exp_data = 24'h020306 + ((j >= 2) ? 24'd1 : 24'd0) + ((j >= 6) ? 24'd1 : 24'd0);
      checks++;
      if (tk_if.data_ch !== exp_data) begin
        failures++;
        $display("FAIL mode3_data cyc%0d: got %h expected %h", j, tk_if.data_ch, exp_data);
      end
      checks++;
      if (tk_if.sec_tick !== 1'b0) begin
        failures++;
        $display("FAIL mode3_tick cyc%0d: got %b expected 0", j, tk_if.sec_tick);
      end
    end
    // Assert reset between clock edges: outputs must clear without waiting for a clock.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tk_if.data_ch !== 24'h0 || {tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: got data=%h pulses=%b expected data=000000 pulses=000",
               tk_if.data_ch, {tk_if.sec_tick, tk_if.day_wrap, tk_if.loaded});
    end
    step();
    tk_if.rezhim = 2'd0;
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (tk_if.data_ch !== ((i == 4) ? 24'h000001 : 24'h000000) || tk_if.sec_tick !== (i == 4)) begin
        failures++;
        $display("FAIL restart_after_reset cyc%0d: got data=%h tick=%b expected data=%h tick=%b",
                 i, tk_if.data_ch, tk_if.sec_tick, (i == 4) ? 24'h000001 : 24'h000000, (i == 4));
      end
    end
    $display("mode 3 run then mid-second reset, time now %h", tk_if.data_ch);
  endtask

  initial begin
    test_reset();
    test_day_wrap();
    test_range_check();
    test_load_vs_tick();
    test_hold();
    test_mode3_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
